// File: rtl/resp_arbiter.sv
// Round-robin scheduler that shares the response-gearbox input among NREQ sources.
// One source is granted per message and keeps the grant until its last word; words
// move only inside PHY gap windows, and a stall timeout plus a message-length cap
// stop any single source from wedging the gearbox.
module resp_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IW      = 56,
  parameter int unsigned MAXW    = 16,
  parameter int unsigned TIMEOUT = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_last,
  input  logic [NREQ*IW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               gap_en,
  output logic [IW-1:0]      out_data,
  output logic               out_valid,
  output logic               out_last,
  output logic [2:0]         out_src,
  output logic               abort,
  output logic               err_sticky
);

  localparam int unsigned GW = $clog2(NREQ);
  localparam int unsigned WW = $clog2(MAXW);
  localparam int unsigned SW = $clog2(TIMEOUT);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] gnt_q, gnt_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [SW-1:0] scnt_q, scnt_d;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  int unsigned   cand;
  logic [GW-1:0] gnt_next;

  logic          xfer;
  logic          msg_end;
  logic          forced_end;
  logic          timeout;

  // First requesting source at or after rr_q, wrapping modulo NREQ
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(rr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!pick_found && req_valid[GW'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = GW'(cand);
      end
    end
  end

  // Pointer value that hands priority to the source after the current grant
  always_comb begin
    gnt_next = (gnt_q == GW'(NREQ - 1)) ? '0 : gnt_q + GW'(1);
  end

  // Next-state, handshake and counter logic
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    wcnt_d     = wcnt_q;
    scnt_d     = scnt_q;
    req_ready  = '0;
    xfer       = 1'b0;
    msg_end    = 1'b0;
    forced_end = 1'b0;
    timeout    = 1'b0;
    case (state_q)
      IDLE: begin
        if (gap_en && pick_found) begin
          gnt_d   = pick_idx;
          wcnt_d  = '0;
          scnt_d  = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        req_ready[gnt_q] = gap_en;
        xfer = gap_en & req_valid[gnt_q];
        if (xfer) begin
          wcnt_d     = wcnt_q + WW'(1);
          scnt_d     = '0;
          forced_end = !req_last[gnt_q] && (wcnt_q == WW'(MAXW - 1));
          msg_end    = req_last[gnt_q] || (wcnt_q == WW'(MAXW - 1));
          if (msg_end) begin
            rr_d    = gnt_next;
            state_d = IDLE;
          end
        end else if (gap_en) begin
          // Leaving at the terminal count means scnt never needs to wrap
          if (scnt_q == SW'(TIMEOUT - 1)) begin
            timeout = 1'b1;
            rr_d    = gnt_next;
            state_d = IDLE;
          end else begin
            scnt_d = scnt_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      wcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  // Registered gearbox-facing stage; data and source hold between words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_src    <= '0;
      abort      <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      out_valid  <= xfer;
      out_last   <= xfer & msg_end;
      abort      <= timeout;
      err_sticky <= err_sticky | forced_end | timeout;
      if (xfer) begin
        out_data <= req_data[32'(gnt_q) * IW +: IW];
        out_src  <= 3'(gnt_q);
      end
    end
  end

endmodule

// File: tb/tb_resp_arbiter.sv
// Bench for resp_arbiter: table vectors, directed corner sequences and random
// traffic, all compared against a transaction-level reference model.
module tb_resp_arbiter;

  localparam int unsigned NREQ    = 4;
  localparam int unsigned IW      = 56;
  localparam int unsigned MAXW    = 16;
  localparam int unsigned TIMEOUT = 32;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_last;
  logic [NREQ*IW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               gap_en;
  logic [IW-1:0]      out_data;
  logic               out_valid;
  logic               out_last;
  logic [2:0]         out_src;
  logic               abort;
  logic               err_sticky;

  always #5 clk = ~clk;

  resp_arbiter #(.NREQ(NREQ), .IW(IW), .MAXW(MAXW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
    .req_ready(req_ready), .gap_en(gap_en),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_src(out_src), .abort(abort), .err_sticky(err_sticky)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: who owns the gearbox, how many words it has sent and how
  // long it has been silent inside gap windows.
  bit            m_busy;
  int            m_gnt, m_words, m_stall, m_rr, m_os;
  bit            m_ov, m_ol, m_ab, m_err;
  logic [IW-1:0] m_od;

  // Observation counters for the directed sequences
  int cyc_no, n_ov, n_ol, n_ab, t_ov, t_ab, ol_at, last_src;

  typedef struct {
    logic [NREQ-1:0] v;
    logic [NREQ-1:0] l;
    logic            g;
    logic [NREQ-1:0] rdy;
    logic            ov;
    logic [2:0]      src;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_gnt = 0; m_words = 0; m_stall = 0; m_rr = 0; m_os = 0;
    m_ov = 0; m_ol = 0; m_ab = 0; m_err = 0; m_od = '0;
  endtask

  task automatic clr_mon();
    n_ov = 0; n_ol = 0; n_ab = 0; t_ov = 0; t_ab = 0; ol_at = 0; last_src = 0;
  endtask

  function automatic logic [NREQ-1:0] m_ready();
    return (m_busy && gap_en) ? (NREQ'(1) << m_gnt) : '0;
  endfunction

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    bit nv, nl, nab;
    nv = 0; nl = 0; nab = 0;
    if (!m_busy) begin
      if (gap_en) begin
        for (int k = 0; k < int'(NREQ); k++) begin
          int s;
          s = (m_rr + k) % NREQ;
          if (req_valid[s]) begin
            m_busy = 1; m_gnt = s; m_words = 0; m_stall = 0;
            break;
          end
        end
      end
    end else if (gap_en) begin
      if (req_valid[m_gnt]) begin
        m_words++;
        m_stall = 0;
        nv = 1;
        m_od = req_data[m_gnt*IW +: IW];
        m_os = m_gnt;
        if (req_last[m_gnt] || m_words == int'(MAXW)) begin
          nl = 1;
          if (!req_last[m_gnt]) m_err = 1;
          m_busy = 0;
          m_rr = (m_gnt + 1) % NREQ;
        end
      end else begin
        m_stall++;
        if (m_stall == int'(TIMEOUT)) begin
          nab = 1; m_err = 1; m_busy = 0;
          m_rr = (m_gnt + 1) % NREQ;
        end
      end
    end
    m_ov = nv; m_ol = nl; m_ab = nab;
  endtask

  task automatic check_model();
    chk("req_ready", 64'(req_ready), 64'(m_ready()));
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("out_last", 64'(out_last), 64'(m_ol));
    chk("abort", 64'(abort), 64'(m_ab));
    chk("err_sticky", 64'(err_sticky), 64'(m_err));
    chk("out_data", 64'(out_data), 64'(m_od));
    chk("out_src", 64'(out_src), 64'(m_os));
    cyc_no++;
    if (out_valid === 1'b1) begin
      n_ov++; t_ov = cyc_no; last_src = int'(out_src);
    end
    if (out_last === 1'b1) begin
      n_ol++; ol_at = n_ov;
    end
    if (abort === 1'b1) begin
      n_ab++; t_ab = cyc_no;
    end
  endtask

  task automatic drive(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l, input logic g);
    req_valid = v;
    req_last  = l;
    gap_en    = g;
    for (int i = 0; i < int'(NREQ); i++) req_data[i*IW +: IW] = IW'({$urandom, $urandom});
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l, input logic g);
    drive(v, l, g);
    #1;
    check_model();
    step();
  endtask

  task automatic probe(input logic [NREQ-1:0] v, input logic g, input string nm,
                       input logic [NREQ-1:0] exp_rdy);
    drive(v, '0, g);
    #1;
    chk(nm, 64'(req_ready), 64'(exp_rdy));
    check_model();
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive('0, '0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Source src offers n words (last on the final one if lastflag); gap_en is
  // low for glen cycles starting at local cycle gfrom; other sources hold valid.
  task automatic send_msg(input int src, input int n, input bit lastflag,
                          input int gfrom, input int glen, input logic [NREQ-1:0] other);
    int w, k;
    logic g, acc;
    logic [NREQ-1:0] v, l;
    w = 0; k = 0;
    while (w < n && k < 400) begin
      g = !(k >= gfrom && k < gfrom + glen);
      v = (NREQ'(1) << src) | other;
      l = (lastflag && w == n - 1) ? (NREQ'(1) << src) : '0;
      drive(v, l, g);
      #1;
      check_model();
      acc = m_busy && (m_gnt == src) && g;
      step();
      if (acc) w++;
      k++;
    end
    chk("send_msg_words", 64'(w), 64'(n));
  endtask

  initial begin
    int p;
    logic [NREQ-1:0] rv, rl;

    tbl[0]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 3'd0};
    tbl[1]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b0, 3'd0};
    tbl[2]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 3'd0};
    tbl[3]  = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b0, 3'd0};
    tbl[4]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 3'd1};
    tbl[5]  = '{4'hF, 4'hF, 1'b1, 4'h4, 1'b0, 3'd0};
    tbl[6]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 3'd2};
    tbl[7]  = '{4'hF, 4'hF, 1'b1, 4'h8, 1'b0, 3'd0};
    tbl[8]  = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 3'd3};
    tbl[9]  = '{4'hF, 4'hF, 1'b1, 4'h1, 1'b0, 3'd0};
    tbl[10] = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b1, 3'd0};
    tbl[11] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 3'd0};
    tbl[12] = '{4'hF, 4'hF, 1'b1, 4'h2, 1'b0, 3'd0};
    tbl[13] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b1, 3'd1};
    tbl[14] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 3'd0};
    tbl[15] = '{4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 3'd0};

    cyc_no = 0;
    clr_mon();
    do_reset();

    // Reset values
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_err_sticky", 64'(err_sticky), 64'(0));
    chk("rst_out_src", 64'(out_src), 64'(0));

    // Round-robin over 1-word messages, with gap windows closing
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].l, tbl[i].g);
      #1;
      chk("tbl_ready", 64'(req_ready), 64'(tbl[i].rdy));
      chk("tbl_valid", 64'(out_valid), 64'(tbl[i].ov));
      chk("tbl_last", 64'(out_last), 64'(tbl[i].ov));
      if (tbl[i].ov) chk("tbl_src", 64'(out_src), 64'(tbl[i].src));
      check_model();
      step();
    end

    // Single 3-word message from source 0, then priority moves to source 1
    do_reset(); clr_mon();
    send_msg(0, 3, 1'b1, 999, 0, '0);
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b1);
    chk("three_word_count", 64'(n_ov), 64'(3));
    chk("three_word_last_pos", 64'(ol_at), 64'(3));
    chk("three_word_src", 64'(last_src), 64'(0));
    cyc(4'b0011, '0, 1'b1);
    probe(4'b0011, 1'b1, "rr_after_msg", 4'b0010);

    // gap_en low for 5 cycles mid-message
    do_reset(); clr_mon();
    send_msg(3, 6, 1'b1, 3, 5, '0);
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b1);
    chk("gap_word_count", 64'(n_ov), 64'(6));
    chk("gap_last_count", 64'(n_ol), 64'(1));
    chk("gap_no_abort", 64'(n_ab), 64'(0));

    // Source 2 goes silent after one word: timeout, then grant moves to 3
    do_reset(); clr_mon();
    send_msg(2, 1, 1'b0, 999, 0, '0);
    p = 0;
    while (n_ab == 0 && p < 100) begin
      cyc(4'b1001, '0, 1'b1);
      p++;
    end
    chk("abort_seen", 64'(n_ab), 64'(1));
    chk("abort_delay", 64'(t_ab - t_ov), 64'(TIMEOUT));
    chk("abort_err", 64'(err_sticky), 64'(1));
    probe(4'b1001, 1'b1, "grant_after_abort", 4'b1000);

    // 20 words with no last: forced end at the MAXW-th word
    do_reset(); clr_mon();
    send_msg(1, 20, 1'b0, 999, 0, '0);
    cyc('0, '0, 1'b1);
    cyc('0, '0, 1'b1);
    chk("maxw_word_count", 64'(n_ov), 64'(20));
    chk("maxw_last_pos", 64'(ol_at), 64'(MAXW));
    chk("maxw_last_count", 64'(n_ol), 64'(1));
    chk("maxw_err", 64'(err_sticky), 64'(1));

    // Reset asserted while source 1 is mid-message
    cyc(4'b0010, '0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_out_last", 64'(out_last), 64'(0));
    chk("midrst_err", 64'(err_sticky), 64'(0));
    chk("midrst_out_src", 64'(out_src), 64'(0));
    chk("midrst_out_data", 64'(out_data), 64'(0));
    chk("midrst_ready", 64'(req_ready), 64'(0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(4'b1100, '0, 1'b1);
    probe(4'b1100, 1'b1, "grant_after_reset", 4'b0100);

    // Random traffic against the model
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      int pv;
      pv = (blk % 3 == 0) ? 70 : ((blk % 3 == 1) ? 40 : 95);
      for (int c = 0; c < 500; c++) begin
        for (int i = 0; i < int'(NREQ); i++) begin
          rv[i] = ($urandom_range(99) < 32'(pv));
          rl[i] = ($urandom_range(99) < 25);
        end
        cyc(rv, rl, $urandom_range(99) < 85);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
